// File: rtl/i2c_pkg.sv
// Shared I2C receive-path constants: default filter length, period counter width
// and the filter counter sizing.
package i2c_pkg;

  localparam int unsigned FILTER_LEN_DEF = 3;
  localparam int unsigned CNT_W_DEF      = 8;
  localparam int unsigned FILTER_LEN_MAX = 15;
  localparam int unsigned FILT_CNT_W     = 4;

endpackage

// File: rtl/i2c_bus_monitor_if.sv
// Bus-monitor signal bundle: raw pad lines and enable in, filtered lines and events out.
// master = controller side, slave = the monitor itself.
interface i2c_bus_monitor_if
  import i2c_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
);

  logic             mon_en;
  logic             scl_i;
  logic             sda_i;
  logic             scl_f;
  logic             sda_f;
  logic             scl_rise;
  logic             scl_fall;
  logic             start_det;
  logic             stop_det;
  logic             bus_busy;
  logic [CNT_W-1:0] scl_high_cnt;

  modport master (
    output mon_en, scl_i, sda_i,
    input  scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det, bus_busy, scl_high_cnt
  );

  modport slave (
    input  mon_en, scl_i, sda_i,
    output scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det, bus_busy, scl_high_cnt
  );

endinterface

// File: rtl/i2c_glitch_filter.sv
// Two-flop synchronizer plus stability filter for one open-drain bus line.
// The filtered value only follows the synced value after FILTER_LEN consecutive mismatches.
module i2c_glitch_filter
  import i2c_pkg::*;
#(
  parameter int unsigned FILTER_LEN = FILTER_LEN_DEF
) (
  input  logic clk_i,
  input  logic rst_n,
  input  logic en_i,
  input  logic line_i,
  output logic line_s_o,
  output logic line_f_o
);

  if (FILTER_LEN < 1 || FILTER_LEN > FILTER_LEN_MAX) begin : g_bad_len
    $error("i2c_glitch_filter: FILTER_LEN out of range");
  end

  localparam logic [FILT_CNT_W-1:0] CNT_LAST = FILT_CNT_W'(FILTER_LEN - 1);
  localparam logic [FILT_CNT_W-1:0] CNT_ONE  = FILT_CNT_W'(1);

  logic [1:0]            sync_q;
  logic                  filt_q, filt_d;
  logic [FILT_CNT_W-1:0] cnt_q, cnt_d;

  assign line_s_o = sync_q[1];
  assign line_f_o = filt_q;

  // Disabled: track the synced line directly so re-enabling never sees a stale mismatch.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (!en_i) begin
      filt_d = sync_q[1];
    end else if (sync_q[1] != filt_q) begin
      if (cnt_q == CNT_LAST) filt_d = sync_q[1];
      else                   cnt_d  = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
      filt_q <= 1'b1;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], line_i};
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/i2c_bus_monitor.sv
// I2C receive front end: filtered SCL/SDA, edge and START/STOP pulses, bus-busy, SCL high time.
// Define I2C_MON_PERIOD_EN to build the SCL high-period counter; otherwise scl_high_cnt is 0.
module i2c_bus_monitor
  import i2c_pkg::*;
#(
  parameter int unsigned FILTER_LEN = FILTER_LEN_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF
) (
  input logic              clk_i,
  input logic              rst_n,
  i2c_bus_monitor_if.slave bus
);

  logic scl_s, sda_s, scl_f, sda_f;
  logic scl_p_q, sda_p_q;
  logic scl_rise_q, scl_fall_q, start_q, stop_q, busy_q;
  logic scl_rise_d, scl_fall_d, start_d, stop_d, busy_d;

  i2c_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
    .clk_i(clk_i), .rst_n(rst_n), .en_i(bus.mon_en),
    .line_i(bus.scl_i), .line_s_o(scl_s), .line_f_o(scl_f)
  );

  i2c_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
    .clk_i(clk_i), .rst_n(rst_n), .en_i(bus.mon_en),
    .line_i(bus.sda_i), .line_s_o(sda_s), .line_f_o(sda_f)
  );

  // START/STOP require SCL high on both sides, so a joint SCL+SDA change is only an SCL edge.
  always_comb begin
    scl_rise_d = scl_f & ~scl_p_q;
    scl_fall_d = ~scl_f & scl_p_q;
    start_d    = scl_f & scl_p_q & sda_p_q & ~sda_f;
    stop_d     = scl_f & scl_p_q & ~sda_p_q & sda_f;
    busy_d     = busy_q;
    if (start_d)     busy_d = 1'b1;
    else if (stop_d) busy_d = 1'b0;
  end

  // While disabled the previous-value flops preload the value the filters load next.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      scl_p_q    <= 1'b1;
      sda_p_q    <= 1'b1;
      scl_rise_q <= 1'b0;
      scl_fall_q <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else if (!bus.mon_en) begin
      scl_p_q    <= scl_s;
      sda_p_q    <= sda_s;
      scl_rise_q <= 1'b0;
      scl_fall_q <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      scl_p_q    <= scl_f;
      sda_p_q    <= sda_f;
      scl_rise_q <= scl_rise_d;
      scl_fall_q <= scl_fall_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.scl_f     = scl_f;
  assign bus.sda_f     = sda_f;
  assign bus.scl_rise  = scl_rise_q;
  assign bus.scl_fall  = scl_fall_q;
  assign bus.start_det = start_q;
  assign bus.stop_det  = stop_q;
  assign bus.bus_busy  = busy_q;

`ifdef I2C_MON_PERIOD_EN
  logic [CNT_W-1:0] per_q, per_d, hcnt_q, hcnt_d;

  // The rising cycle itself already has scl_f high, so the count restarts at 1.
  always_comb begin
    per_d  = per_q;
    hcnt_d = hcnt_q;
    if (scl_rise_d)                   per_d = CNT_W'(1);
    else if (scl_f && (per_q != '1))  per_d = per_q + CNT_W'(1);
    if (scl_fall_d)                   hcnt_d = per_q;
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      per_q  <= '0;
      hcnt_q <= '0;
    end else if (!bus.mon_en) begin
      per_q  <= '0;
      hcnt_q <= '0;
    end else begin
      per_q  <= per_d;
      hcnt_q <= hcnt_d;
    end
  end

  assign bus.scl_high_cnt = hcnt_q;
`else
  assign bus.scl_high_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_i2c_bus_monitor.sv
// Scoreboard bench for i2c_bus_monitor: stimulus queues expected pulses, a negedge monitor
// pops and compares them; level outputs are checked directly at chosen cycles.
module tb_i2c_bus_monitor;
  import i2c_pkg::*;

  localparam int CW  = CNT_W_DEF;
  localparam int LAT = 5;          // raw edge n -> pulse seen after edge n+5 (FILTER_LEN = 3)
  localparam int SAT = 255;        // all-ones for CNT_W = 8

  typedef struct {
    int kind;                      // 0 rise, 1 fall, 2 start, 3 stop
    int at;
    int cnt;
  } ev_t;

  logic clk_i = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  ev_t  exp_q[$];
  ev_t  e;
  logic scl_r, sda_r;
  int   rise_n;
  int   n;

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc++;

  i2c_bus_monitor_if #(.CNT_W(CW)) bif ();

  i2c_bus_monitor #(.FILTER_LEN(FILTER_LEN_DEF), .CNT_W(CW)) dut (
    .clk_i(clk_i),
    .rst_n(rst_n),
    .bus  (bif)
  );

  function automatic string kname(int k);
    case (k)
      0: return "scl_rise";
      1: return "scl_fall";
      2: return "start_det";
      default: return "stop_det";
    endcase
  endfunction

  function automatic int hcnt(int h);
`ifdef I2C_MON_PERIOD_EN
    return (h > SAT) ? SAT : h;
`else
    return 0;
`endif
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(int k, int at, int c);
    ev_t x;
    x.kind = k; x.at = at; x.cnt = c;
    exp_q.push_back(x);
  endtask

  task automatic set_scl(logic v);
    int m;
    m = cyc + 1;
    if (v && !scl_r) begin
      push(0, m + LAT, 0);
      rise_n = m;
    end else if (!v && scl_r) begin
      push(1, m + LAT, hcnt(m - rise_n));
    end
    bif.scl_i = v;
    scl_r     = v;
  endtask

  task automatic set_sda(logic v);
    if (scl_r && (v != sda_r)) push(v ? 3 : 2, cyc + 1 + LAT, 0);
    bif.sda_i = v;
    sda_r     = v;
  endtask

  task automatic set_both(logic s, logic d);
    set_scl(s);
    bif.sda_i = d;
    sda_r     = d;
  endtask

  task automatic wait_until(int c);
    while (cyc < c) @(negedge clk_i);
  endtask

  task automatic idle(int k);
    repeat (k) @(negedge clk_i);
  endtask

  // Scoreboard monitor
  always @(negedge clk_i) begin
    if (rst_n === 1'b1) begin
      logic p[4];
      p[0] = bif.scl_rise; p[1] = bif.scl_fall; p[2] = bif.start_det; p[3] = bif.stop_det;
      for (int k = 0; k < 4; k++) begin
        if (p[k]) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected %s at cycle %0d", kname(k), cyc);
          end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.at != cyc) begin
              errors++;
              $display("FAIL event: got %s at cycle %0d expected %s at cycle %0d",
                       kname(k), cyc, kname(e.kind), e.at);
            end else if (k == 1 && int'(bif.scl_high_cnt) != e.cnt) begin
              errors++;
              $display("FAIL scl_high_cnt: got %0d expected %0d (cycle %0d)",
                       bif.scl_high_cnt, e.cnt, cyc);
            end
          end
        end
      end
      while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
        e = exp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL missing %s: got none expected at cycle %0d", kname(e.kind), e.at);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish before time limit");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    bif.mon_en = 1'b1; bif.scl_i = 1'b1; bif.sda_i = 1'b1;
    scl_r = 1'b1; sda_r = 1'b1; rise_n = 0;
    idle(3);
    chk("rst_busy", bif.bus_busy, 0);
    rst_n = 1'b1;
    idle(10);
    chk("idle_scl_f", bif.scl_f, 1);
    chk("idle_sda_f", bif.sda_f, 1);
    chk("idle_busy", bif.bus_busy, 0);
    chk("idle_cnt", bif.scl_high_cnt, 0);

    // Park SCL low through the disabled path: no pulses expected.
    bif.mon_en = 1'b0;
    idle(1);
    bif.scl_i = 1'b0; scl_r = 1'b0;
    idle(6);
    chk("dis_scl_follow", bif.scl_f, 0);
    chk("dis_cnt", bif.scl_high_cnt, 0);
    bif.mon_en = 1'b1;
    idle(6);

    // Rise latency and a 40-cycle high phase
    n = cyc + 1;
    set_scl(1'b1);
    wait_until(n + 3);
    chk("scl_f_pre", bif.scl_f, 0);
    wait_until(n + 4);
    chk("scl_f_rise", bif.scl_f, 1);
    wait_until(n + 39);
    set_scl(1'b0);
    wait_until(n + 55);

    // 2-cycle SDA glitch while SCL high
    set_scl(1'b1);
    idle(10);
    bif.sda_i = 1'b0;
    idle(2);
    bif.sda_i = 1'b1;
    idle(10);
    chk("glitch_sda_f", bif.sda_f, 1);
    chk("glitch_busy", bif.bus_busy, 0);

    // START, repeated START, STOP
    n = cyc + 1;
    set_sda(1'b0);
    wait_until(n + 4);
    chk("busy_pre_start", bif.bus_busy, 0);
    wait_until(n + 5);
    chk("busy_start", bif.bus_busy, 1);
    idle(10);
    set_scl(1'b0);  idle(10);
    set_sda(1'b1);  idle(10);
    set_scl(1'b1);  idle(10);
    set_sda(1'b0);  idle(10);
    chk("busy_rep_start", bif.bus_busy, 1);
    n = cyc + 1;
    set_sda(1'b1);
    wait_until(n + 6);
    chk("busy_stop", bif.bus_busy, 0);
    idle(5);

    // Joint SCL/SDA toggles: SCL edges only
    set_both(1'b0, 1'b0); idle(10);
    set_both(1'b1, 1'b1); idle(10);
    set_both(1'b0, 1'b0); idle(10);
    chk("joint_busy", bif.bus_busy, 0);
    set_sda(1'b1); idle(10);

    // 300-cycle high phase saturates the count
    set_scl(1'b1);
    idle(300);
    set_scl(1'b0);
    idle(12);
`ifdef I2C_MON_PERIOD_EN
    chk("sat_cnt", bif.scl_high_cnt, SAT);
`else
    chk("sat_cnt_off", bif.scl_high_cnt, 0);
`endif

    // Disable mid-transfer, move lines, re-enable silently
    set_scl(1'b1); idle(10);
    set_sda(1'b0); idle(10);
    chk("busy_before_dis", bif.bus_busy, 1);
    bif.mon_en = 1'b0;
    idle(1);
    chk("dis_busy", bif.bus_busy, 0);
    chk("dis_cnt_clr", bif.scl_high_cnt, 0);
    bif.scl_i = 1'b0; bif.sda_i = 1'b1; scl_r = 1'b0; sda_r = 1'b1;
    idle(8);
    chk("dis_scl_low", bif.scl_f, 0);
    bif.mon_en = 1'b1;
    idle(10);

    // Reset mid-transfer
    set_scl(1'b1); idle(10);
    set_sda(1'b0); idle(10);
    chk("busy_before_rst", bif.bus_busy, 1);
    chk("sda_f_before_rst", bif.sda_f, 0);
    rst_n = 1'b0;
    #1;
    chk("rst_async_busy", bif.bus_busy, 0);
    chk("rst_async_sda_f", bif.sda_f, 1);
    chk("rst_async_cnt", bif.scl_high_cnt, 0);
    bif.scl_i = 1'b1; bif.sda_i = 1'b1; scl_r = 1'b1; sda_r = 1'b1;
    idle(3);
    rst_n = 1'b1;
    idle(15);
    chk("post_rst_busy", bif.bus_busy, 0);
    chk("post_rst_sda_f", bif.sda_f, 1);

    idle(5);
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i2c_bus_monitor.md
# i2c_bus_monitor

Receive-side front end for the I2C controller: it observes the raw SCL/SDA bus lines and turns them into clean, clk_i-synchronous signals and events. The clock divisor drives SCL out onto the bus; this block is the opposite path, recovering bus timing. It synchronizes and glitch-filters both lines, emits single-cycle SCL edge and START/STOP pulses, tracks bus-busy, and measures the SCL high time. Its outputs feed the controller FSM, for arbitration and clock-stretch detection, and the status registers.

## Interface
- FILTER_LEN, 3: consecutive stable synced samples required before a filtered line changes; legal range 1..15.
- CNT_W, 8: width of the SCL-high period counter.
- clk_i  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- mon_en  in  1  monitor enable.
- scl_i  in  1  raw SCL from the pad, asynchronous.
- sda_i  in  1  raw SDA from the pad, asynchronous.
- scl_f  out  1  filtered SCL; reset value 1.
- sda_f  out  1  filtered SDA; reset value 1.
- scl_rise  out  1  one-cycle pulse on a filtered SCL 0->1 transition; reset value 0.
- scl_fall  out  1  one-cycle pulse on a filtered SCL 1->0 transition; reset value 0.
- start_det  out  1  one-cycle pulse on START or repeated START; reset value 0.
- stop_det  out  1  one-cycle pulse on STOP; reset value 0.
- bus_busy  out  1  high between a START and the following STOP; reset value 0.
- scl_high_cnt  out  CNT_W  length of the last complete SCL high phase, in clk_i cycles; reset value 0.

## Operation
- Synchronizer: each line passes through 2 flops, reset to 1. The synchronizer runs regardless of mon_en.
- Filter, per line:
  - A counter clears whenever the synced value equals the filtered value.
  - While the two differ, the counter increments each cycle.
  - When the counter reaches FILTER_LEN, the filtered value takes the synced value and the counter clears.
  - Any mismatch shorter than FILTER_LEN cycles is discarded.
- Events are registered and compare the current filtered value with the previous filtered value:
  - scl_rise / scl_fall: SCL changed.
  - start_det: SDA 1->0 while filtered SCL is 1 in both the previous and the current cycle.
  - stop_det: SDA 0->1 under the same SCL condition.
- Simultaneous SCL and SDA filtered change in the same cycle: only the SCL edge pulse fires. No START or STOP is reported.
- bus_busy: set by start_det, cleared by stop_det. A repeated START keeps it set.
- Period counter:
  - Cleared on scl_rise; increments each cycle while scl_f = 1; saturates at all-ones.
  - On scl_fall, the counter value is latched into scl_high_cnt.
- mon_en = 0:
  - Filtered outputs load the synced values directly each cycle and filter counters are held at 0, so re-enabling causes no spurious edges.
  - All pulses are 0, bus_busy = 0, the period counter and scl_high_cnt are cleared.
- rst_n asserted mid-transfer: every output returns to its reset value immediately. No pulses fire on release.

## Timing
- Raw line stable from clk_i edge n:
  - Synced value visible after edge n+1.
  - Filtered output changes at edge n+1+FILTER_LEN.
  - Event pulse is high for the cycle following edge n+2+FILTER_LEN.
  - With the default FILTER_LEN = 3, end-to-end latency is 5 cycles.
- Filter rejects a synced glitch of up to FILTER_LEN-1 cycles.
- Minimum resolvable SCL phase: FILTER_LEN cycles.
- All event pulses last exactly 1 clk_i cycle. They are never back-to-back for the same line unless the phase is at least FILTER_LEN cycles.
- scl_high_cnt updates on the same edge that asserts scl_fall.

## Configuration
- I2C_MON_PERIOD_EN defined: period counter and scl_high_cnt are implemented as described above.
- Undefined: no counter logic is generated and scl_high_cnt is tied to 0. All other behaviour is identical.

## Structure
- Shared package i2c_pkg holds:
  - default FILTER_LEN and CNT_W localparams;
  - the legal FILTER_LEN maximum (15);
  - the filter counter width (4 bits).
- Sub-module i2c_glitch_filter (synchronizer plus filter for one line), instantiated once for SCL and once for SDA.
- Edge/event detection, bus_busy and the period counter stay in the top level.

## Test plan
- Reset, then both lines held 1 -> scl_f = sda_f = 1, no pulses, bus_busy = 0, scl_high_cnt = 0.
- FILTER_LEN = 3, scl_i 0->1 sampled at edge 10 -> scl_f rises at edge 14, scl_rise high for 1 cycle after edge 15.
- 2-cycle low glitch on sda_i while SCL is high -> sda_f stays 1, no start_det.
- SCL high, SDA 1->0, later SDA 0->1 -> one start_det, bus_busy = 1, then one stop_det, bus_busy = 0; a repeated START in between keeps bus_busy = 1.
- scl_i and sda_i toggled on the same edge -> scl_rise/scl_fall only, no start_det or stop_det.
- SCL high for 40 cycles -> scl_high_cnt = 40 at scl_fall; high for 300 cycles with CNT_W = 8 -> 255 (saturated); with I2C_MON_PERIOD_EN undefined -> always 0.
